// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Also imported by the apb_slave benches, so keep it free of block-specific detail.
package apb_pkg;

  localparam int APB_ADDRW = 8;
  localparam int APB_DATAW = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB master: one command in, one SETUP/ACCESS transfer out,
// one registered response pulse back. ACCESS is bounded by a wait-state timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDRW   = APB_ADDRW,
  parameter int DATAW   = APB_DATAW,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic [DATAW-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [DATAW-1:0] rsp_rdata,
  output logic             rsp_error,
  output logic [ADDRW-1:0] paddr,
  output logic             pwrite,
  output logic             psel,
  output logic             penable,
  output logic [DATAW-1:0] pwdata,
  input  logic [DATAW-1:0] prdata,
  input  logic             pready,
  input  logic             pslverr
);

  localparam logic [1:0] IDLE   = APB_IDLE;
  localparam logic [1:0] SETUP  = APB_SETUP;
  localparam logic [1:0] ACCESS = APB_ACCESS;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] wcnt;

  assign cmd_ready = (state == IDLE);

  // The command is captured straight into the APB address/data registers,
  // which then hold their values across IDLE until the next handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_write ? cmd_wdata : '0;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          wcnt    <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a timeout landing on the same edge
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= pslverr;
            rsp_rdata <= pwrite ? '0 : prdata;
            state     <= IDLE;
          end else if (wcnt == WAIT_LAST) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
